// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the asyncfifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Requester index width, never narrower than one bit.
  function automatic int id_w(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Beat counter must hold the value MAX_BURST.
  function automatic int beat_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotated priority encoder: first set request at or above rr_ptr, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  logic [ID_W-1:0] cand;

  // Walk offsets from highest to lowest so the smallest offset wins.
  always_comb begin
    found = |req;
    index = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) index = cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one asyncfifo write port between NUM_REQ
// valid/ready requesters, with bounded bursts and a full-stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BURST   = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wpush,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_wfull,
  output logic                          grant_valid,
  output logic [id_w(NUM_REQ)-1:0]      grant_id,
  output logic [STALL_CNT_W-1:0]        stall_cnt
);

  localparam int IW = id_w(NUM_REQ);
  localparam int BW = beat_w(MAX_BURST);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          grant_id_q, grant_id_d;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic                  in_grant;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  acc;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IW)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  // Port-side signals are combinational off the registered grant so a beat
  // can be accepted in the same cycle the requester presents it.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    in_grant  = (state_q == GRANT);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IW'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_data       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = in_grant && !fifo_wfull;
      end
    end
    acc = in_grant && g_valid && !fifo_wfull;
  end

  assign fifo_wpush  = acc;
  assign fifo_wdata  = g_data;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    grant_valid_d = grant_valid_q;
    stall_cnt_d   = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_idx;
          grant_valid_d = 1'b1;
          beat_cnt_d    = '0;
          rr_ptr_d      = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (!g_valid) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
        end else if (fifo_wfull) begin
          // Full never revokes the grant; it only counts lost cycles.
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (g_last || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      beat_cnt_q    <= '0;
      grant_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      beat_cnt_q    <= beat_cnt_d;
      grant_valid_q <= grant_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a transaction-level arbiter model,
// an ideal depth-16 FIFO and queue-driven requesters.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int MB    = 4;
  localparam int SW    = 16;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_wpush;
  logic [DW-1:0]   fifo_wdata;
  logic            fifo_wfull;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [SW-1:0]   stall_cnt;

  always #10 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .MAX_BURST   (MB),
    .STALL_CNT_W (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wpush  (fifo_wpush),
    .fifo_wdata  (fifo_wdata),
    .fifo_wfull  (fifo_wfull),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         bq[N][$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] rx[$];
  int            glog[$];
  logic [DW-1:0] exp_rx[$];
  int            exp_ids[$];
  bit            rd_en;
  bit            prev_gv;

  bit m_granted;
  int m_gid;
  int m_rr;
  int m_beats;
  int m_stall;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_rx(input string nm);
    int errs = 0;
    chk({nm, "_count"}, rx.size(), exp_rx.size());
    for (int k = 0; k < rx.size() && k < exp_rx.size(); k++)
      if (rx[k] !== exp_rx[k]) errs++;
    chk({nm, "_order_errors"}, errs, 0);
  endtask

  task automatic chk_ids(input string nm);
    int errs = 0;
    chk({nm, "_count"}, glog.size(), exp_ids.size());
    for (int k = 0; k < glog.size() && k < exp_ids.size(); k++)
      if (glog[k] != exp_ids[k]) errs++;
    chk({nm, "_order_errors"}, errs, 0);
  endtask

  task automatic model_reset();
    m_granted = 1'b0;
    m_gid     = 0;
    m_rr      = 0;
    m_beats   = 0;
    m_stall   = 0;
    prev_gv   = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (bq[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_last[i]            = bq[i][0].l;
        req_data[i*DW +: DW]   = bq[i][0].d;
      end else begin
        req_valid[i]           = 1'b0;
        req_last[i]            = 1'b0;
        req_data[i*DW +: DW]   = '0;
      end
    end
    fifo_wfull = (fq.size() >= DEPTH);
  endtask

  task automatic add_beat(input int id, input logic [DW-1:0] d, input logic l);
    bq[id].push_back('{d: d, l: l});
  endtask

  // One write-clock cycle: compare at negedge, commit effects at posedge.
  task automatic cycle(input bit rst_mid = 1'b0);
    logic [N-1:0]  er;
    bit            ep;
    logic          c_push;
    logic [DW-1:0] c_wdata;
    logic [N-1:0]  c_ready, c_valid, c_last;
    logic          c_full;
    bit            found;
    @(negedge clk);
    er = '0;
    if (m_granted && !fifo_wfull) er[m_gid] = 1'b1;
    ep = m_granted && req_valid[m_gid] && !fifo_wfull;
    chk("req_ready", req_ready, er);
    chk("fifo_wpush", fifo_wpush, ep);
    if (ep) chk("fifo_wdata", fifo_wdata, bq[m_gid][0].d);
    chk("grant_valid", grant_valid, m_granted);
    chk("grant_id", grant_id, m_gid);
    chk("stall_cnt", stall_cnt, m_stall);
    if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
    prev_gv = grant_valid;
    c_push  = fifo_wpush;
    c_wdata = fifo_wdata;
    c_ready = req_ready;
    c_valid = req_valid;
    c_last  = req_last;
    c_full  = fifo_wfull;
    if (rst_mid) begin
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_wpush", fifo_wpush, 0);
      chk("async_rst_ready", req_ready, 0);
      chk("async_rst_grant_valid", grant_valid, 0);
      chk("async_rst_stall_cnt", stall_cnt, 0);
      model_reset();
      for (int i = 0; i < N; i++) bq[i].delete();
    end
    @(posedge clk);
    if (rst_n) begin
      if (c_push) fq.push_back(c_wdata);
      if (rd_en && fq.size() > 0) rx.push_back(fq.pop_front());
      for (int i = 0; i < N; i++)
        if (c_valid[i] && c_ready[i] && bq[i].size() > 0) bq[i].delete(0);
      if (!m_granted) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && c_valid[(m_rr + k) % N]) begin
            found     = 1'b1;
            m_gid     = (m_rr + k) % N;
            m_granted = 1'b1;
            m_beats   = 0;
            m_rr      = (m_gid + 1) % N;
          end
        end
      end else if (!c_valid[m_gid]) begin
        m_granted = 1'b0;
      end else if (c_full) begin
        if (m_stall < (1 << SW) - 1) m_stall++;
      end else begin
        m_beats++;
        if (c_last[m_gid] || m_beats == MB) m_granted = 1'b0;
      end
    end
    #1 drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) bq[i].delete();
    fq.delete();
    rx.delete();
    glog.delete();
    drive();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rd_en = 1'b1;
    model_reset();
    drive();
    repeat (2) cycle();
    chk("reset_grant_valid", grant_valid, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_wpush", fifo_wpush, 0);
    rst_n = 1'b1;

    // Single requester, three beats ending on last.
    do_reset();
    add_beat(0, 32'h10, 1'b0);
    add_beat(0, 32'h11, 1'b0);
    add_beat(0, 32'h12, 1'b1);
    drive();
    repeat (12) cycle();
    exp_ids = '{0};
    chk_ids("single_grants");
    exp_rx = '{32'h10, 32'h11, 32'h12};
    chk_rx("single_rx");
    chk("single_idle_after", grant_valid, 0);

    // Fairness: four requesters, eight beats each, no last.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 8; n++) add_beat(i, DW'(i * 256 + n), 1'b0);
    drive();
    repeat (60) cycle();
    exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_ids("fair_grants");
    exp_rx.delete();
    for (int b = 0; b < 32; b++)
      exp_rx.push_back(DW'(((b / 4) % 4) * 256 + (b / 16) * 4 + (b % 4)));
    chk_rx("fair_rx");

    // Early release by requester 2 while requester 3 waits.
    do_reset();
    add_beat(2, 32'h20, 1'b0);
    add_beat(2, 32'h21, 1'b0);
    for (int n = 0; n < 4; n++) add_beat(3, DW'(32'h30 + n), 1'b0);
    drive();
    repeat (6) cycle();
    add_beat(2, 32'h22, 1'b0);
    add_beat(2, 32'h23, 1'b1);
    drive();
    repeat (20) cycle();
    exp_ids = '{2, 3, 2};
    chk_ids("release_grants");
    exp_rx = '{32'h20, 32'h21, 32'h30, 32'h31, 32'h32, 32'h33, 32'h22, 32'h23};
    chk_rx("release_rx");

    // Full stall: reader held while requester 1 offers 20 beats.
    do_reset();
    rd_en = 1'b0;
    for (int v = 2; v <= 21; v++) add_beat(1, DW'(v), 1'b0);
    drive();
    repeat (40) cycle();
    chk("stall_fifo_level", fq.size(), 16);
    chk("stall_cnt_held", stall_cnt, 19);
    rd_en = 1'b1;
    repeat (60) cycle();
    exp_rx.delete();
    for (int v = 2; v <= 21; v++) exp_rx.push_back(DW'(v));
    chk_rx("stall_rx");

    // Asynchronous reset during the second beat of requester 0.
    rx.delete();
    glog.delete();
    for (int n = 0; n < 4; n++) add_beat(0, DW'(32'h40 + n), 1'b0);
    drive();
    repeat (2) cycle();
    cycle(1'b1);
    repeat (2) cycle();
    rst_n = 1'b1;
    add_beat(2, 32'h52, 1'b1);
    drive();
    repeat (6) cycle();
    exp_ids = '{0, 2};
    chk_ids("rst_grants");
    exp_rx = '{32'h40, 32'h52};
    chk_rx("rst_rx");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of one asyncfifo (wpush/wdata/wfull) between NUM_REQ requesters in the write-clock domain.
Each requester uses a valid/ready handshake. A grant holds for a burst of up to MAX_BURST beats, or until the requester signals last or drops valid.
The block sits directly in front of the asyncfifo write side, e.g. several core-side producers feeding one cross-clock queue.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, payload width; matches the asyncfifo DATA_WIDTH
MAX_BURST, 4, maximum accepted beats per grant (>=1)
STALL_CNT_W, 16, width of the saturating full-stall counter

Ports:
clk  in  1  write-side clock; same clock as the asyncfifo wclk
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester end-of-burst marker for the current beat
req_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  beat accepted this cycle (one-hot or zero)
fifo_wpush  out  1  drives asyncfifo wpush
fifo_wdata  out  DATA_WIDTH  drives asyncfifo wdata
fifo_wfull  in  1  from asyncfifo wfull
grant_valid  out  1  a grant is active
grant_id  out  clog2(NUM_REQ)  index of the granted requester
stall_cnt  out  STALL_CNT_W  saturating count of cycles with a granted valid beat blocked by fifo_wfull

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; rr_ptr = 0; beat_cnt = 0; grant_id = 0; stall_cnt = 0.
  - grant_valid, req_ready and fifo_wpush drop to 0 immediately, not at the next edge.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register that index as grant_id, set grant_valid, clear beat_cnt, set rr_ptr = (grant_id+1) mod NUM_REQ, go to GRANT.
  - Arbitration latency is 1 cycle; no beat is accepted in IDLE.
- GRANT, per cycle with g = grant_id:
  - Accept condition: acc = req_valid[g] && !fifo_wfull.
  - Outputs are combinational: req_ready[g] = !fifo_wfull; all other req_ready bits are 0; fifo_wpush = acc; fifo_wdata = req_data[g] (a don't-care when acc=0).
  - On acc: beat_cnt++. If req_last[g] or beat_cnt == MAX_BURST-1, go to IDLE and clear grant_valid.
  - If req_valid[g] is low: go to IDLE (release). No push occurs this cycle.
  - If req_valid[g] && fifo_wfull: stay in GRANT, stall_cnt++ (saturating at all-ones). The grant is never revoked because of full.
- After a burst ends, a requester with pending data waits behind all other valid requesters, per round-robin.
- Requester rule: req_data and req_last are held stable while req_valid && !req_ready. The arbiter does not buffer beats.
- fifo_wpush is never high while fifo_wfull is high. Exactly one FIFO push occurs per accepted beat; no beat is duplicated or lost.
- With a single active requester, a new grant re-arbitrates through IDLE. Throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Width rules:
  - beat_cnt is clog2(MAX_BURST+1) bits wide.
  - rr_ptr and grant_id are clog2(NUM_REQ) bits wide, with a minimum of 1.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-burst:
  - Any beat not yet accepted is discarded by the arbiter.
  - FIFO contents are governed by the asyncfifo's own resets.

Decomposition:
- Package fifo_arb_pkg:
  - State enum arb_state_t {IDLE, GRANT}.
  - Width helper functions for id and beat counter widths.
- Sub-module rr_picker: combinational; inputs (req vector, rr_ptr); outputs (found, index). It is a rotated priority encoder and is unit-testable on its own.

Test Plan:
- Setup for all scenarios: NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=32; asyncfifo with ADDR_WIDTH=4 (depth 16); write clock period 20, read clock period 10.
- Single requester: req 0 sends 0x10, 0x11, 0x12 with last on 0x12 -> grant_id=0 one cycle after valid; three consecutive fifo_wpush pulses; reader sees 0x10..0x12; state returns to IDLE.
- Fairness: all 4 requesters valid continuously, 8 beats each, data = id*0x100+n -> grant order 0,1,2,3,0,1,2,3 with 4 beats per grant; reader receives the blocks in that order.
- Full stall: reader held off; req 1 offers 20 beats (values 2..21) -> 16 accepted, then req_ready[1]=0 and fifo_wpush=0 while wfull, stall_cnt increments every cycle; after the reader drains, all 20 values arrive in order with no duplicates.
- Early release: req 2 drops valid after 2 beats while req 3 is valid -> GRANT to IDLE, then grant_id=3; req 2's next request waits behind req 3's burst.
- Reset mid-burst: rst_n=0 during beat 2 of req 0 -> fifo_wpush, req_ready and grant_valid go 0 asynchronously; stall_cnt=0; after release, a lone req 2 is granted first (rr_ptr=0 search).
